clkgen_cfg_sequencer: RTL and testbench

//  Configures the external clock generator over the master I2C bus by sequencing register writes.
//  - Init: plays a table of {reg,val} pairs from a ROM.
//  - Runtime: accepts single-register updates from the slave control path (frequency changes).
//  - Byte-level I2C master: drives it through a valid/ready command handshake.
//  - Serialises both sources onto the one I2C master and sits between it and the transceiver top.

---
 rtl/clkgen_cfg_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_clkgen_cfg_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_cfg_sequencer.sv
// Sequences clock-generator register writes (init ROM table, then runtime updates) onto a
// byte-level I2C master through a valid/ready command handshake.
module clkgen_cfg_sequencer #(
  parameter int unsigned TableLen  = 16,
  parameter int unsigned AddrW     = 5,
  parameter logic [6:0]  DevAddr   = 7'h60,
  parameter int unsigned Retries   = 3,
  parameter int unsigned BootDelay = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic [AddrW-1:0] rom_addr_o,
  input  logic [15:0]      rom_data_i,
  input  logic             upd_valid_i,
  input  logic [7:0]       upd_reg_i,
  input  logic [7:0]       upd_val_i,
  output logic             upd_ready_o,
  output logic             i2c_cmd_valid_o,
  input  logic             i2c_cmd_ready_i,
  output logic             i2c_cmd_start_o,
  output logic             i2c_cmd_stop_o,
  output logic [7:0]       i2c_cmd_byte_o,
  input  logic             i2c_done_i,
  input  logic             i2c_nack_i,
  output logic             busy_o,
  output logic             init_done_o,
  output logic             error_o
);

  localparam int unsigned CntW = (BootDelay > 1) ? $clog2(BootDelay) : 1;
  localparam int unsigned TryW = (Retries > 0) ? $clog2(Retries + 1) : 1;
  localparam logic [CntW-1:0]  BootLast = CntW'(BootDelay - 1);
  localparam logic [TryW-1:0]  TryMax   = TryW'(Retries);
  localparam logic [AddrW-1:0] IdxLast  = AddrW'(TableLen - 1);

  typedef enum logic [2:0] {
    StBoot, StIdle, StFetch, StSend, StWaitDone, StNext
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] boot_cnt_q;
  logic            start_pend_q;
  logic [AddrW-1:0] idx_q;
  logic [1:0]      byte_q;
  logic [TryW-1:0] try_q;
  logic            table_q;
  logic            fetch_ph_q;
  logic [7:0]      reg_q;
  logic [7:0]      val_q;
  logic            cmd_valid_q;
  logic            cmd_start_q;
  logic            cmd_stop_q;
  logic [7:0]      cmd_byte_q;
  logic            init_done_q;
  logic            error_q;

  // {start, stop, byte} for byte slot 0..2 of a register write.
  function automatic logic [9:0] cmd_fields(input logic [1:0] slot, input logic [7:0] r,
                                            input logic [7:0] v);
    case (slot)
      2'd0:    return {1'b1, 1'b0, DevAddr, 1'b0};
      2'd1:    return {2'b00, r};
      default: return {2'b01, v};
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StBoot;
      boot_cnt_q   <= '0;
      start_pend_q <= 1'b0;
      idx_q        <= '0;
      byte_q       <= '0;
      try_q        <= '0;
      table_q      <= 1'b0;
      fetch_ph_q   <= 1'b0;
      reg_q        <= '0;
      val_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_start_q  <= 1'b0;
      cmd_stop_q   <= 1'b0;
      cmd_byte_q   <= '0;
      init_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        StBoot: begin
          if (start_i) start_pend_q <= 1'b1;
          if (boot_cnt_q == BootLast) state_q <= StIdle;
          else boot_cnt_q <= boot_cnt_q + CntW'(1);
        end
        StIdle: begin
          if (start_i || start_pend_q) begin
            start_pend_q <= 1'b0;
            init_done_q  <= 1'b0;
            error_q      <= 1'b0;
            idx_q        <= '0;
            table_q      <= 1'b1;
            fetch_ph_q   <= 1'b0;
            try_q        <= '0;
            state_q      <= StFetch;
          end else if (upd_valid_i && upd_ready_o) begin
            reg_q       <= upd_reg_i;
            val_q       <= upd_val_i;
            table_q     <= 1'b0;
            try_q       <= '0;
            byte_q      <= 2'd0;
            cmd_valid_q <= 1'b1;
            {cmd_start_q, cmd_stop_q, cmd_byte_q} <= cmd_fields(2'd0, upd_reg_i, upd_val_i);
            state_q     <= StSend;
          end
        end
        StFetch: begin
          // First cycle lets the ROM register the address; data is captured on the second.
          if (!fetch_ph_q) begin
            fetch_ph_q <= 1'b1;
          end else begin
            fetch_ph_q  <= 1'b0;
            reg_q       <= rom_data_i[15:8];
            val_q       <= rom_data_i[7:0];
            byte_q      <= 2'd0;
            cmd_valid_q <= 1'b1;
            {cmd_start_q, cmd_stop_q, cmd_byte_q} <=
                cmd_fields(2'd0, rom_data_i[15:8], rom_data_i[7:0]);
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (i2c_cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (i2c_done_i) begin
            if (!i2c_nack_i) begin
              if (byte_q == 2'd2) begin
                state_q <= StNext;
              end else begin
                byte_q      <= byte_q + 2'd1;
                cmd_valid_q <= 1'b1;
                {cmd_start_q, cmd_stop_q, cmd_byte_q} <= cmd_fields(byte_q + 2'd1, reg_q, val_q);
                state_q     <= StSend;
              end
            end else if (try_q < TryMax) begin
              try_q       <= try_q + TryW'(1);
              byte_q      <= 2'd0;
              cmd_valid_q <= 1'b1;
              {cmd_start_q, cmd_stop_q, cmd_byte_q} <= cmd_fields(2'd0, reg_q, val_q);
              state_q     <= StSend;
            end else begin
              error_q <= 1'b1;
              try_q   <= '0;
              state_q <= StIdle;
            end
          end
        end
        StNext: begin
          try_q <= '0;
          if (!table_q) begin
            state_q <= StIdle;
          end else if (idx_q == IdxLast) begin
            init_done_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            idx_q      <= idx_q + AddrW'(1);
            fetch_ph_q <= 1'b0;
            state_q    <= StFetch;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  // Combinational so a same-cycle start can withdraw the offer before a handshake completes.
  assign upd_ready_o     = (state_q == StIdle) && init_done_q && !start_i && !start_pend_q;
  assign rom_addr_o      = idx_q;
  assign i2c_cmd_valid_o = cmd_valid_q;
  assign i2c_cmd_start_o = cmd_start_q;
  assign i2c_cmd_stop_o  = cmd_stop_q;
  assign i2c_cmd_byte_o  = cmd_byte_q;
  assign busy_o          = (state_q != StIdle) && (state_q != StBoot);
  assign init_done_o     = init_done_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_clkgen_cfg_sequencer.sv
// Bench for clkgen_cfg_sequencer: randomized I2C master responder and ROM, with expected
// byte streams computed from the write/retry rules as plain loops.
module tb_clkgen_cfg_sequencer;

  localparam int unsigned TL      = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned RETRIES = 3;
  localparam int unsigned BOOT    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          upd_valid = 1'b0;
  logic [7:0]    upd_reg = '0;
  logic [7:0]    upd_val = '0;
  logic          upd_ready;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic          cmd_start;
  logic          cmd_stop;
  logic [7:0]    cmd_byte;
  logic          done = 1'b0;
  logic          nack = 1'b0;
  logic          busy;
  logic          init_done;
  logic          error;

  always #5 clk = ~clk;

  clkgen_cfg_sequencer #(
    .TableLen (TL),
    .AddrW    (AW),
    .DevAddr  (7'h60),
    .Retries  (RETRIES),
    .BootDelay(BOOT)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .upd_valid_i    (upd_valid),
    .upd_reg_i      (upd_reg),
    .upd_val_i      (upd_val),
    .upd_ready_o    (upd_ready),
    .i2c_cmd_valid_o(cmd_valid),
    .i2c_cmd_ready_i(cmd_ready),
    .i2c_cmd_start_o(cmd_start),
    .i2c_cmd_stop_o (cmd_stop),
    .i2c_cmd_byte_o (cmd_byte),
    .i2c_done_i     (done),
    .i2c_nack_i     (nack),
    .busy_o         (busy),
    .init_done_o    (init_done),
    .error_o        (error)
  );

  logic [15:0] rom [TL];
  always @(posedge clk) rom_data <= rom[rom_addr];

  logic [16:0] outs;
  assign outs = {rom_addr, upd_ready, cmd_valid, cmd_start, cmd_stop, cmd_byte, busy, init_done,
                 error};

  int          n_checks = 0;
  int          n_pass = 0;
  logic [9:0]  log_q[$];
  logic [9:0]  exp_q[$];
  bit          nack_map [256];
  int          ord = 0;
  bit          exp_err;
  bit          exp_done;
  int          exp_fetched;
  int          force_ord = -1;
  int          force_len = 0;
  bit          spur_en = 1'b0;
  int          max_addr;

  typedef enum {MIdle, MWait, MAcc, MBusy, MDone} mst_e;
  mst_e m_st = MIdle;
  int   wait_cnt;
  int   dcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] fld(input int b, input logic [15:0] ent);
    if (b == 0) return 10'h2C0;
    if (b == 1) return {2'b00, ent[15:8]};
    return {2'b01, ent[7:0]};
  endfunction

  // Expected bytes for one table run given which accepted-byte ordinals get NACKed.
  task automatic model_table();
    int  n;
    int  tries;
    bit  ok;
    bit  nacked;
    n = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    exp_fetched = 0;
    for (int e = 0; e < int'(TL); e++) begin
      tries = 0;
      ok = 1'b0;
      exp_fetched = e;
      while (!ok) begin
        nacked = 1'b0;
        for (int b = 0; b < 3 && !nacked; b++) begin
          exp_q.push_back(fld(b, rom[e]));
          nacked = nack_map[n % 256];
          n++;
        end
        if (!nacked) ok = 1'b1;
        else begin
          tries++;
          if (tries > int'(RETRIES)) begin
            exp_err = 1'b1;
            return;
          end
        end
      end
    end
    exp_done = 1'b1;
  endtask

  task automatic clear_nacks();
    for (int k = 0; k < 256; k++) nack_map[k] = 1'b0;
  endtask

  task automatic wait_step();
    check("valid_held", cmd_valid, 1);
    if (log_q.size() < exp_q.size())
      check($sformatf("cmd_fields[%0d]", log_q.size()), {cmd_start, cmd_stop, cmd_byte},
            exp_q[log_q.size()]);
    else
      check("cmd_count", log_q.size() + 1, exp_q.size());
    if (wait_cnt == 0) begin
      cmd_ready = 1'b1;
      log_q.push_back({cmd_start, cmd_stop, cmd_byte});
      m_st = MAcc;
    end else begin
      wait_cnt--;
    end
  endtask

  // I2C master responder: random ready/done latency, NACK by accepted-byte ordinal.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st = MIdle;
        cmd_ready = 1'b0;
        done = 1'b0;
        nack = 1'b0;
      end else begin
        case (m_st)
          MIdle: begin
            done = 1'b0;
            nack = 1'b0;
            if (cmd_valid) begin
              wait_cnt = (force_ord == log_q.size()) ? force_len : $urandom_range(0, 3);
              m_st = MWait;
              wait_step();
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
              done = 1'b1;
              nack = 1'b1;
            end
          end
          MWait: wait_step();
          MAcc: begin
            cmd_ready = 1'b0;
            check("single_outstanding", cmd_valid, 0);
            dcnt = $urandom_range(0, 3);
            m_st = MBusy;
          end
          MBusy: begin
            if (dcnt == 0) begin
              done = 1'b1;
              nack = nack_map[ord % 256];
              ord++;
              m_st = MDone;
            end else begin
              dcnt--;
            end
          end
          default: begin
            done = 1'b0;
            nack = 1'b0;
            m_st = MIdle;
          end
        endcase
      end
    end
  end

  task automatic prep_run();
    log_q.delete();
    ord = 0;
    model_table();
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic wait_idle(input string tag, input bit mid);
    int cyc;
    bit seen;
    bit fired;
    cyc = 0;
    seen = 1'b0;
    fired = 1'b0;
    max_addr = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (busy) seen = 1'b1;
      if (mid && !fired && log_q.size() >= 4) begin
        start = 1'b1;
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (seen && !busy) break;
    end
    start = 1'b0;
    check({tag, "_finished"}, {seen, busy}, 2'b10);
    repeat (6) @(negedge clk);
  endtask

  task automatic finish_run(input string tag, input bit mid);
    wait_idle(tag, mid);
    check({tag, "_quiet"}, busy, 0);
    compare_stream(tag);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_init_done"}, init_done, exp_done);
    check({tag, "_last_fetch"}, max_addr, exp_fetched);
  endtask

  task automatic run_table(input string tag, input bit mid);
    prep_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    finish_run(tag, mid);
  endtask

  initial begin
    int cyc;
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
    cyc = 0;
  end

  initial begin
    int cyc;
    rom[0] = 16'h03FF;
    rom[1] = 16'h104F;
    rom[2] = 16'h2155;
    rom[3] = 16'h3A01;
    clear_nacks();

    // Reset values and start latched during BOOT.
    repeat (2) @(negedge clk);
    check("reset_outputs", outs, 0);
    prep_run();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("boot_not_busy", busy, 0);
    finish_run("t1_table", 1'b0);

    // Ready held low 10 clocks on the first byte, ignored start mid-table.
    force_ord = 0;
    force_len = 10;
    run_table("t5_hold", 1'b1);
    force_ord = -1;

    // NACK twice on byte 1 of entry 0.
    clear_nacks();
    nack_map[1] = 1'b1;
    nack_map[3] = 1'b1;
    run_table("t2_retry", 1'b0);

    // Every attempt of entry 1 NACKed: retries exhausted.
    clear_nacks();
    for (int k = 3; k < 7; k++) nack_map[k] = 1'b1;
    run_table("t3_abort", 1'b0);

    // Runtime update held off until init_done.
    clear_nacks();
    log_q.delete();
    upd_reg = 8'h2A;
    upd_val = 8'h80;
    upd_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("upd_ready_before_init", upd_ready, 0);
    check("no_cmd_before_init", log_q.size(), 0);
    prep_run();
    exp_q.push_back(10'h2C0);
    exp_q.push_back(10'h02A);
    exp_q.push_back(10'h180);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!upd_ready && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("upd_accept_after_init", {upd_ready, init_done, busy}, 3'b110);
    @(negedge clk) upd_valid = 1'b0;
    wait_idle("t4_update", 1'b0);
    compare_stream("t4_update");
    check("t4_status", {busy, init_done, error}, 3'b010);

    // Randomized tables, NACK patterns and spurious done pulses.
    spur_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < int'(TL); i++) rom[i] = 16'($urandom);
      clear_nacks();
      for (int k = 0; k < 48; k++) nack_map[k] = ($urandom_range(0, 5) == 0);
      run_table($sformatf("rand%0d", it), 1'b0);
    end
    spur_en = 1'b0;

    // Async reset during byte 2 of entry 1, then BOOT restarts.
    clear_nacks();
    prep_run();
    force_ord = 5;
    force_len = 30;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(log_q.size() == 5 && cmd_valid) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reached_byte2", {log_q.size() == 5, cmd_valid}, 2'b11);
    #3 rst_n = 1'b0;
    #1 check("t6_async_reset_outputs", outs, 0);
    force_ord = -1;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    prep_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_boot_idle", {busy, cmd_valid}, 2'b00);
    end
    finish_run("t6_rerun", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
